sd_fifo_rx_drainer: RTL and testbench

Receive-direction counterpart of the TX filler in the SD data path. It accepts 32-bit words from the SD receive-side data serial logic into a small internal FIFO and writes them to system memory as a Wishbone master, one single-beat write per word, at consecutive word addresses from a programmed base. Both the FIFO and the bus engine run on the single Wishbone clock.

---
 rtl/sd_fifo_rx_drainer.sv | 114 +++++++++++
 tb/tb_sd_fifo_rx_drainer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sd_fifo_rx_drainer.sv
// rtl/sd_fifo_rx_drainer.sv - SD receive FIFO drained to memory as single-beat Wishbone writes
module sd_fifo_rx_drainer #(
    parameter int DEPTH      = 8,
    parameter int MEM_OFFSET = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    output logic [2:0]  m_wb_cti_o,
    output logic [1:0]  m_wb_bte_o,
    input  logic        en,
    input  logic [31:0] adr,
    input  logic        wr,
    input  logic [31:0] dat_i,
    output logic        full,
    output logic        empty,
    output logic        ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, BUS} state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q;
    logic [8:0]      offset_q;
    logic            ovf_q;
    logic [31:0]     dat_q;
    logic            cyc;
    logic            push, pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign ovf   = ovf_q;

    assign push = wr && !full && en;
    // The only pop is the launch of a bus cycle: the head word moves into dat_q.
    assign pop  = (state_q == IDLE) && en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en && !empty) state_d = BUS;
            BUS:     if (m_wb_ack_i)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!en) state_d = IDLE;
    end

    always_comb begin
        cyc = (state_q == BUS);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= dat_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            offset_q <= '0;
            ovf_q    <= 1'b0;
            dat_q    <= '0;
        end else if (!en) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            offset_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
                dat_q  <= mem_q[rptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (wr && full) ovf_q <= 1'b1;
            if ((state_q == BUS) && m_wb_ack_i) offset_q <= offset_q + 9'(MEM_OFFSET);
        end
    end

    assign m_wb_adr_o = adr + {23'b0, offset_q};
    assign m_wb_dat_o = dat_q;
    assign m_wb_sel_o = 4'b1111;
    assign m_wb_we_o  = cyc;
    assign m_wb_cyc_o = cyc;
    assign m_wb_stb_o = cyc;
    assign m_wb_cti_o = 3'b000;
    assign m_wb_bte_o = 2'b00;

endmodule

// File: tb/tb_sd_fifo_rx_drainer.sv
// tb/tb_sd_fifo_rx_drainer.sv - directed self-checking bench for sd_fifo_rx_drainer
module tb_sd_fifo_rx_drainer;

    logic        clk = 1'b0;
    logic        rst, en, wr, ack;
    logic [31:0] adr, dat_i;
    logic [31:0] wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        full, empty, ovf;

    int n_checks = 0;
    int n_errors = 0;

    sd_fifo_rx_drainer #(.DEPTH(8), .MEM_OFFSET(4)) dut (
        .clk(clk), .rst(rst),
        .m_wb_adr_o(wb_adr), .m_wb_dat_o(wb_dat), .m_wb_sel_o(wb_sel),
        .m_wb_we_o(wb_we), .m_wb_cyc_o(wb_cyc), .m_wb_stb_o(wb_stb),
        .m_wb_ack_i(ack), .m_wb_cti_o(wb_cti), .m_wb_bte_o(wb_bte),
        .en(en), .adr(adr), .wr(wr), .dat_i(dat_i),
        .full(full), .empty(empty), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic flush();
        en = 1'b0;
        step();
        en = 1'b1;
    endtask

    // Wait for a strobe, check the write, hold off 'waits' cycles, then ack once.
    task automatic expect_write(input logic [31:0] ea, input logic [31:0] ed, input int waits);
        int t = 0;
        while (!wb_stb && t < 50) begin
            step();
            t++;
        end
        check("stb_seen", wb_stb, 1);
        check("wr_adr", wb_adr, ea);
        check("wr_dat", wb_dat, ed);
        check("wr_we_sel_cti", {wb_we, wb_sel, wb_cti, wb_bte}, {1'b1, 4'hF, 3'b000, 2'b00});
        repeat (waits) begin
            step();
            check("adr_stable", wb_adr, ea);
            check("stb_held", wb_stb, 1);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("cyc_after_ack", wb_cyc, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; wr = 1'b0; ack = 1'b0;
        adr = 32'h0000_1000; dat_i = '0;
        step();
        step();
        check("rst_cyc", {wb_cyc, wb_stb, wb_we}, 0);
        check("rst_flags", {full, empty, ovf}, 3'b010);
        check("rst_dat", wb_dat, 0);
        check("rst_adr", wb_adr, 32'h1000);
        check("rst_consts", {wb_sel, wb_cti, wb_bte}, {4'hF, 3'b000, 2'b00});
        rst = 1'b0;

        // Single word
        en = 1'b1;
        wr = 1'b1; dat_i = 32'hDEAD_BEEF;
        step();
        wr = 1'b0;
        check("single_nonempty", empty, 0);
        check("single_no_stb_yet", wb_stb, 0);
        step();
        check("single_stb_latency", wb_stb, 1);
        expect_write(32'h1000, 32'hDEAD_BEEF, 0);
        check("single_offset", wb_adr, 32'h1004);
        check("single_empty", empty, 1);

        // Burst with two wait states per ack
        flush();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    wr = 1'b1; dat_i = 32'(i);
                    step();
                end
                wr = 1'b0;
            end
            begin
                for (int k = 0; k < 8; k++) expect_write(32'h1000 + 32'(4 * k), 32'(k), 2);
            end
        join
        check("burst_empty", empty, 1);

        // Overflow: slave stalls while DEPTH+2 words arrive
        flush();
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1; dat_i = 32'h100 + 32'(i);
            step();
            if (i == 8) check("ovf_full_no_ovf", {full, ovf}, 2'b10);
        end
        wr = 1'b0;
        check("ovf_set", ovf, 1);
        check("ovf_full", full, 1);
        check("ovf_inflight", {wb_cyc, wb_dat}, {1'b1, 32'h100});
        for (int i = 0; i < 9; i++) expect_write(32'h1000 + 32'(4 * i), 32'h100 + 32'(i), 0);
        step();
        step();
        check("ovf_no_tenth", wb_cyc, 0);
        check("ovf_drained", empty, 1);
        check("ovf_sticky", ovf, 1);

        // Abort while a cycle is in flight and data is pending
        wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dat_i = 32'hA0 + 32'(i);
            step();
        end
        wr = 1'b0;
        check("abort_pre", {wb_stb, empty}, 2'b10);
        en = 1'b0;
        step();
        check("abort_cyc", wb_cyc, 0);
        check("abort_flags", {empty, ovf}, 2'b10);
        check("abort_adr", wb_adr, 32'h1000);
        wr = 1'b1; dat_i = 32'h1234;
        step();
        wr = 1'b0;
        check("abort_push_ignored", empty, 1);
        en = 1'b1; ack = 1'b1;
        step();
        ack = 1'b0;
        check("abort_late_ack", {wb_cyc, wb_adr}, {1'b0, 32'h1000});
        wr = 1'b1; dat_i = 32'hCAFE_F00D;
        step();
        wr = 1'b0;
        expect_write(32'h1000, 32'hCAFE_F00D, 1);

        // Offset wrap modulo 512
        flush();
        for (int i = 0; i < 129; i++) begin
            wr = 1'b1; dat_i = 32'h5000 + 32'(i);
            step();
            wr = 1'b0;
            expect_write(32'h1000 + 32'((4 * i) % 512), 32'h5000 + 32'(i), 0);
        end
        check("wrap_offset", wb_adr, 32'h1004);
        adr = 32'hFFFF_FFFC;
        #1;
        check("wrap_adr32", wb_adr, 32'h0000_0000);

        // Reset together with ack during BUS
        adr = 32'h2000;
        wr = 1'b1; dat_i = 32'h77;
        step();
        wr = 1'b0;
        step();
        check("rstmid_pre", wb_stb, 1);
        rst = 1'b1; ack = 1'b1;
        step();
        rst = 1'b0; ack = 1'b0;
        check("rstmid_bus", {wb_cyc, wb_stb, wb_we}, 0);
        check("rstmid_dat", wb_dat, 0);
        check("rstmid_flags", {full, empty, ovf}, 3'b010);
        check("rstmid_adr", wb_adr, 32'h2000);
        step();
        check("rstmid_idle", wb_cyc, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
